// File: rtl/ctrl_pkg.sv
// Shared opcode/ALU/error constants and the FSM state type for the
// multi-cycle controller.
package ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_J   = 4'b1111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: ALU operation, writeback selects and
// instruction class flags for one opcode.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int ALU_W = 3
) (
  input  logic [OP_W-1:0]  op,
  output logic [ALU_W-1:0] alu_con,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             is_rtype,
  output logic             is_lw,
  output logic             is_sw,
  output logic             is_bne,
  output logic             is_j,
  output logic             illegal
);

  always_comb begin
    alu_con    = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_W'(OP_ADD): begin is_rtype = 1'b1; reg_dst = 1'b1; alu_con = ALU_W'(ALU_ADD); end
      OP_W'(OP_SUB): begin is_rtype = 1'b1; reg_dst = 1'b1; alu_con = ALU_W'(ALU_SUB); end
      OP_W'(OP_AND): begin is_rtype = 1'b1; reg_dst = 1'b1; alu_con = ALU_W'(ALU_AND); end
      OP_W'(OP_OR):  begin is_rtype = 1'b1; reg_dst = 1'b1; alu_con = ALU_W'(ALU_OR);  end
      // SLT writes back through the rt field, hence reg_dst stays low
      OP_W'(OP_SLT): begin is_rtype = 1'b1; alu_con = ALU_W'(ALU_SLT); end
      OP_W'(OP_LW):  begin is_lw = 1'b1; mem_to_reg = 1'b1; alu_con = ALU_W'(ALU_ADD); end
      OP_W'(OP_SW):  begin is_sw = 1'b1; alu_con = ALU_W'(ALU_ADD); end
      OP_W'(OP_BNE): begin is_bne = 1'b1; alu_con = ALU_W'(ALU_SUB); end
      OP_W'(OP_J):   begin is_j = 1'b1; alu_con = ALU_W'(ALU_ADD); end
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-wait timeout, halt at instruction boundary, traps and retire count.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int ALU_W = 3,
  parameter int TO_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             branch,
  output logic             jump,
  output logic [ALU_W-1:0] alu_con,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  state_t            state, state_next;
  logic [TO_W-1:0]   wait_cnt;
  logic [OP_W-1:0]   op_q, dec_op;
  logic [1:0]        err_code_q, trap_code;
  logic [CNT_W-1:0]  retired_q;
  logic              retire, boundary, timeout;
  logic [ALU_W-1:0]  d_alu_con;
  logic              d_reg_dst, d_mem_to_reg, d_rtype, d_lw, d_sw, d_bne, d_j, d_illegal;

  // DECODE must judge the live opcode before op_q has captured it
  assign dec_op  = (state == S_DECODE) ? opcode : op_q;
  assign timeout = (wait_cnt == {TO_W{1'b1}}) && !mem_ready;

  ctrl_decode #(.OP_W(OP_W), .ALU_W(ALU_W)) u_decode (
    .op         (dec_op),
    .alu_con    (d_alu_con),
    .reg_dst    (d_reg_dst),
    .mem_to_reg (d_mem_to_reg),
    .is_rtype   (d_rtype),
    .is_lw      (d_lw),
    .is_sw      (d_sw),
    .is_bne     (d_bne),
    .is_j       (d_j),
    .illegal    (d_illegal)
  );

  always_comb begin
    state_next    = state;
    trap_code     = ERR_NONE;
    retire        = 1'b0;
    boundary      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_con       = '0;
    halted        = 1'b0;
    err           = 1'b0;
    if (reset) begin
      state_next = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (timeout) begin
            state_next = S_TRAP;
            trap_code  = ERR_TIMEOUT;
          end else begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write   = 1'b1;
              pc_write   = 1'b1;
              state_next = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (d_illegal) begin
            state_next = S_TRAP;
            trap_code  = ERR_ILLEGAL;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_con = d_alu_con;
          if (d_rtype) begin
            state_next = S_WB;
          end else if (d_lw || d_sw) begin
            alu_src    = 1'b1;
            state_next = S_MEM;
          end else if (d_bne) begin
            branch        = 1'b1;
            pc_write_cond = 1'b1;
            boundary      = 1'b1;
          end else if (d_j) begin
            jump     = 1'b1;
            pc_write = 1'b1;
            boundary = 1'b1;
          end else begin
            state_next = S_TRAP;
            trap_code  = ERR_ILLEGAL;
          end
        end
        S_MEM: begin
          if (timeout) begin
            state_next = S_TRAP;
            trap_code  = ERR_TIMEOUT;
          end else begin
            iord      = 1'b1;
            mem_read  = d_lw;
            mem_write = d_sw;
            if (mem_ready && d_lw) state_next = S_WB;
            else if (mem_ready)    boundary   = 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = d_reg_dst;
          mem_to_reg = d_mem_to_reg;
          boundary   = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
          if (!halt_req) state_next = S_FETCH;
        end
        S_TRAP:  err = 1'b1;
        default: begin
          state_next = S_TRAP;
          trap_code  = ERR_NONE;
        end
      endcase
      // Completed instruction: count it unless parking in HALT instead
      if (boundary) begin
        if (halt_req) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      op_q       <= '0;
      err_code_q <= ERR_NONE;
      retired_q  <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (!mem_ready && (state == S_FETCH || state == S_MEM))
        wait_cnt <= wait_cnt + TO_W'(1);
      else
        wait_cnt <= '0;
      if (state == S_DECODE) op_q <= opcode;
      if (state_next == S_TRAP && state != S_TRAP) err_code_q <= trap_code;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign err_code = reset ? ERR_NONE : err_code_q;
  assign retired  = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: an instruction-level model expands each instruction
// into its expected per-cycle output trace, which is replayed against the DUT.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, mem_ready, halt_req;
  logic [3:0]  opcode;
  logic        pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src, branch, jump;
  logic [2:0]  alu_con;
  logic        halted, err;
  logic [1:0]  err_code;
  logic [15:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(4), .ALU_W(3), .TO_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_con(alu_con), .halted(halted), .err(err), .err_code(err_code), .retired(retired)
  );

  typedef struct packed {
    logic pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
    logic reg_write, reg_dst, mem_to_reg, alu_src, branch, jump;
    logic [2:0]  alu_con;
    logic        halted, err;
    logic [1:0]  err_code;
    logic [15:0] retired;
  } obs_t;

  typedef struct {
    logic       rst, rdy, hreq;
    logic [3:0] op;
    obs_t       exp;
  } cyc_t;

  cyc_t       trace[$];
  int         m_retired;
  logic [1:0] m_err;
  int         n_pass, n_total;
  logic [3:0] legal_ops[9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                               4'b1000, 4'b1010, 4'b1110, 4'b1111};

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(15, 0));
  endfunction

  // 0 illegal, 1 R-type, 2 LW, 3 SW, 4 BNE, 5 J
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111: return 1;
      4'b1000: return 2;
      4'b1010: return 3;
      4'b1110: return 4;
      4'b1111: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'b0110, 4'b1110: return 3'b110;
      4'b0000:          return 3'b000;
      4'b0001:          return 3'b001;
      4'b0111:          return 3'b111;
      default:          return 3'b010;
    endcase
  endfunction

  function automatic obs_t base();
    obs_t o = '0;
    o.retired  = 16'(m_retired);
    o.err_code = m_err;
    return o;
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic hreq,
                      input logic [3:0] op, input obs_t o);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.hreq = hreq; c.op = op; c.exp = o;
    trace.push_back(c);
  endtask

  task automatic finish_instr(input logic hreq);
    obs_t o;
    if (hreq) begin
      int n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        o = base(); o.halted = 1'b1; push(1'b0, rbit(), 1'b1, rop(), o);
      end
      o = base(); o.halted = 1'b1; push(1'b0, rbit(), 1'b0, rop(), o);
    end else begin
      m_retired = (m_retired + 1) % 65536;
    end
  endtask

  task automatic gen_instr(input logic [3:0] op, input int fw, input int mw, input logic hreq);
    obs_t o;
    int   c = cls(op);
    for (int i = 0; i < fw; i++) begin
      o = base(); o.mem_read = 1'b1; push(1'b0, 1'b0, rbit(), rop(), o);
    end
    o = base(); o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(1'b0, 1'b1, rbit(), rop(), o);
    o = base(); push(1'b0, rbit(), rbit(), op, o);
    if (c == 0) begin
      m_err = 2'b01;
      return;
    end
    o = base(); o.alu_con = alu_of(op);
    if (c == 2 || c == 3) o.alu_src = 1'b1;
    if (c == 4) begin o.branch = 1'b1; o.pc_write_cond = 1'b1; end
    if (c == 5) begin o.jump = 1'b1; o.pc_write = 1'b1; end
    if (c >= 4) begin
      push(1'b0, rbit(), hreq, rop(), o);
      finish_instr(hreq);
      return;
    end
    push(1'b0, rbit(), rbit(), rop(), o);
    if (c == 2 || c == 3) begin
      o = base(); o.iord = 1'b1; o.mem_read = (c == 2); o.mem_write = (c == 3);
      for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rbit(), rop(), o);
      if (c == 3) begin
        push(1'b0, 1'b1, hreq, rop(), o);
        finish_instr(hreq);
        return;
      end
      push(1'b0, 1'b1, rbit(), rop(), o);
    end
    o = base(); o.reg_write = 1'b1; o.reg_dst = (c == 1 && op != 4'b0111); o.mem_to_reg = (c == 2);
    push(1'b0, rbit(), hreq, rop(), o);
    finish_instr(hreq);
  endtask

  task automatic gen_timeout(input bit in_mem);
    obs_t o;
    logic [3:0] op = 4'b0000;
    if (in_mem) begin
      op = rbit() ? 4'b1000 : 4'b1010;
      o = base(); o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
      push(1'b0, 1'b1, rbit(), rop(), o);
      o = base(); push(1'b0, rbit(), rbit(), op, o);
      o = base(); o.alu_con = 3'b010; o.alu_src = 1'b1; push(1'b0, rbit(), rbit(), rop(), o);
    end
    for (int i = 0; i < 15; i++) begin
      o = base();
      if (in_mem) begin
        o.iord = 1'b1; o.mem_read = (op == 4'b1000); o.mem_write = (op == 4'b1010);
      end else begin
        o.mem_read = 1'b1;
      end
      push(1'b0, 1'b0, rbit(), rop(), o);
    end
    o = base(); push(1'b0, 1'b0, rbit(), rop(), o);
    m_err = 2'b10;
  endtask

  task automatic gen_trap(input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      o = base(); o.err = 1'b1; push(1'b0, rbit(), rbit(), rop(), o);
    end
  endtask

  task automatic gen_reset(input int n);
    m_retired = 0;
    m_err     = 2'b00;
    for (int i = 0; i < n; i++) push(1'b1, rbit(), rbit(), rop(), '0);
  endtask

  task automatic pin(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL pin_%s got %0d want %0d", nm, got, want);
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.pc_write = pc_write; a.pc_write_cond = pc_write_cond; a.iord = iord;
    a.ir_write = ir_write; a.mem_read = mem_read; a.mem_write = mem_write;
    a.reg_write = reg_write; a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg;
    a.alu_src = alu_src; a.branch = branch; a.jump = jump; a.alu_con = alu_con;
    a.halted = halted; a.err = err; a.err_code = err_code; a.retired = retired;
    return a;
  endfunction

  initial begin
    int   l0, r, snap;
    obs_t got;
    n_pass = 0; n_total = 0; m_retired = 0; m_err = 2'b00;
    reset = 1'b1; mem_ready = 1'b0; halt_req = 1'b0; opcode = 4'b0000;

    // Directed scenarios, with the model's own trace pinned to hand numbers
    gen_reset(2);
    l0 = trace.size(); gen_instr(4'b0010, 0, 0, 1'b0);
    pin("add_len", trace.size() - l0, 4);
    pin("add_irw", int'(trace[l0].exp.ir_write), 1);
    pin("add_alu", int'(trace[l0 + 2].exp.alu_con), 2);
    pin("add_wb", int'({trace[l0 + 3].exp.reg_write, trace[l0 + 3].exp.reg_dst}), 3);
    pin("add_ret", m_retired, 1);
    l0 = trace.size(); gen_instr(4'b1000, 0, 3, 1'b0);
    pin("lw_len", trace.size() - l0, 8);
    pin("lw_wb", int'(trace[l0 + 7].exp.mem_to_reg), 1);
    gen_reset(1);
    l0 = trace.size(); gen_instr(4'b1110, 0, 0, 1'b0); gen_instr(4'b1111, 0, 0, 1'b0);
    pin("bnej_len", trace.size() - l0, 6);
    pin("bnej_ret", m_retired, 2);
    gen_instr(4'b0101, 1, 0, 1'b0);
    pin("ill_code", int'(m_err), 1);
    gen_trap(12); gen_reset(1);
    gen_timeout(1'b0); gen_trap(4); gen_reset(1);
    gen_instr(4'b0010, 15, 0, 1'b0);
    gen_timeout(1'b1); gen_trap(3); gen_reset(1);
    gen_instr(4'b0111, 0, 0, 1'b0);
    snap = m_retired;
    gen_instr(4'b1010, 1, 2, 1'b1);
    pin("halt_ret", m_retired, snap);
    gen_instr(4'b0001, 0, 0, 1'b0);

    // Randomised instruction stream
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(99, 0);
      if (r < 3) begin
        logic [3:0] bad;
        do bad = rop(); while (cls(bad) != 0);
        gen_instr(bad, $urandom_range(2, 0), 0, 1'b0);
        gen_trap($urandom_range(5, 1)); gen_reset($urandom_range(2, 1));
      end else if (r < 6) begin
        gen_instr(legal_ops[$urandom_range(8, 0)], 0, 0, 1'b0);
        for (int p = $urandom_range(2, 1); p > 0; p--) void'(trace.pop_back());
        gen_reset(1);
      end else if (r < 8) begin
        gen_timeout(bit'(rbit())); gen_trap(2); gen_reset(1);
      end else begin
        gen_instr(legal_ops[$urandom_range(8, 0)],
                  (r < 12) ? 15 : $urandom_range(3, 0),
                  (r < 14) ? 15 : $urandom_range(3, 0),
                  ($urandom_range(9, 0) == 0));
      end
    end

    foreach (trace[i]) begin
      @(negedge clk);
      reset = trace[i].rst; mem_ready = trace[i].rdy;
      halt_req = trace[i].hreq; opcode = trace[i].op;
      #1;
      got = sample();
      n_total++;
      if (got === trace[i].exp) n_pass++;
      else $display("FAIL cycle_%0d outputs got %h want %h", i, got, trace[i].exp);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
